// File: rtl/toll_pkg.sv
// Shared defaults and helpers for the toll datapath slice.
// Build option: define TOLL_SPEED_FINE_EN to enable the speeding surcharge.
package toll_pkg;
  localparam int unsigned TIME_W_DEF     = 16;
  localparam int unsigned BAL_W_DEF      = 16;
  localparam int unsigned FAST_LIMIT_DEF = 1000;
  localparam int unsigned BASE_FEE_DEF   = 20;
  localparam int unsigned FINE_FEE_DEF   = 50;
  localparam int unsigned MAX_VEH        = 3;

  // Add two values and clamp the result to the all-ones value of a w-bit field.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [63:0] lim;
    lim = (64'd1 << w) - 64'd1;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, lim}) ? lim : sum[63:0];
  endfunction
endpackage

// File: rtl/toll_datapath_if.sv
// Controller <-> datapath signal bundle for the toll gate.
interface toll_datapath_if #(
  parameter int unsigned BAL_W = 16
);
  logic             init;
  logic             count;
  logic             cal;
  logic             up;
  logic             down;
  logic             card_present;
  logic [BAL_W-1:0] card_balance;
  logic             valid_Epass;
  logic [1:0]       num_veh;
  logic             done;
  logic             debit_ok;
  logic [BAL_W-1:0] fee;
  logic [BAL_W-1:0] new_balance;
  logic             speeding;

  modport master (
    output init, count, cal, up, down, card_present, card_balance,
    input  valid_Epass, num_veh, done, debit_ok, fee, new_balance, speeding
  );

  modport slave (
    input  init, count, cal, up, down, card_present, card_balance,
    output valid_Epass, num_veh, done, debit_ok, fee, new_balance, speeding
  );
endinterface

// File: rtl/veh_zone_counter.sv
// Saturating 0..MAX_VEH count of vehicles inside the gate zone.
module veh_zone_counter
  import toll_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  output logic [1:0] num_veh
);
  localparam logic [1:0] VEH_MAX = 2'(MAX_VEH);

  always_ff @(posedge clk) begin
    if (reset) begin
      num_veh <= '0;
    end else if (up && !down && num_veh != VEH_MAX) begin
      num_veh <= num_veh + 2'd1;
    end else if (down && !up && num_veh != '0) begin
      num_veh <= num_veh - 2'd1;
    end
  end
endmodule

// File: rtl/toll_datapath.sv
// Transit timing, fee calculation and E-pass debit downstream of the toll controller.
// Build option: define TOLL_SPEED_FINE_EN to enable the speeding surcharge.
module toll_datapath
  import toll_pkg::*;
#(
  parameter int unsigned TIME_W     = TIME_W_DEF,
  parameter int unsigned BAL_W      = BAL_W_DEF,
  parameter int unsigned FAST_LIMIT = FAST_LIMIT_DEF,
  parameter int unsigned BASE_FEE   = BASE_FEE_DEF,
  parameter int unsigned FINE_FEE   = FINE_FEE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  toll_datapath_if.slave    bus
);
  localparam logic [BAL_W-1:0] FEE_SLOW = BAL_W'(sat_add(64'(BASE_FEE), 64'd0, BAL_W));

  logic [TIME_W-1:0] t_cnt;
  logic [BAL_W-1:0]  fee_now;
  logic              fast;

  always_ff @(posedge clk) begin
    if (reset) begin
      t_cnt <= '0;
    end else if (bus.init) begin
      t_cnt <= '0;
    end else if (bus.cal) begin
      t_cnt <= t_cnt;
    end else if (bus.count && t_cnt != '1) begin
      t_cnt <= t_cnt + 1'b1;
    end
  end

`ifdef TOLL_SPEED_FINE_EN
  localparam logic [BAL_W-1:0] FEE_FAST =
    BAL_W'(sat_add(64'(BASE_FEE), 64'(FINE_FEE), BAL_W));

  // A saturated timer means the real transit time is unknown but long: never speeding.
  always_comb begin
    fast    = (32'(t_cnt) < FAST_LIMIT) && (t_cnt != '1);
    fee_now = fast ? FEE_FAST : FEE_SLOW;
  end
`else
  always_comb begin
    fast    = 1'b0;
    fee_now = FEE_SLOW;
  end
`endif

  assign bus.valid_Epass = bus.card_present && (bus.card_balance >= fee_now);

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.done        <= 1'b0;
      bus.debit_ok    <= 1'b0;
      bus.fee         <= '0;
      bus.new_balance <= '0;
      bus.speeding    <= 1'b0;
    end else begin
      bus.done     <= bus.cal;
      bus.debit_ok <= bus.cal && bus.valid_Epass;
      if (bus.cal) begin
        bus.fee         <= fee_now;
        bus.speeding    <= fast;
        bus.new_balance <= bus.valid_Epass ? (bus.card_balance - fee_now) : bus.card_balance;
      end
    end
  end

  veh_zone_counter u_zone (
    .clk     (clk),
    .reset   (reset),
    .up      (bus.up),
    .down    (bus.down),
    .num_veh (bus.num_veh)
  );
endmodule

// File: doc/toll_datapath.md
# toll_datapath

Datapath stage directly downstream of the toll-gate controller FSM. It consumes the controller's `init`/`count`/`cal`/`up`/`down` strobes. It returns `valid_Epass`, `num_veh` and `done` to the controller.

Internally it measures sensor1→sensor2 transit time, classifies speed, computes the fee and debits the E-pass balance. It also tracks how many vehicles are inside the gate zone.

## Interface
- `TIME_W`, 16, transit-time counter width
- `BAL_W`, 16, balance and fee width
- `FAST_LIMIT`, 1000, transit below this cycle count is speeding
- `BASE_FEE`, 20, flat toll
- `FINE_FEE`, 50, speeding surcharge
- `clk` in 1: rising-edge clock
- `reset` in 1: synchronous, active-high
- `init` in 1: clear transit timer (controller START)
- `count` in 1: advance transit timer (controller COUNT_TIME)
- `cal` in 1: one-cycle charge strobe (controller CALC)
- `up` in 1: vehicle entered zone
- `down` in 1: vehicle left zone (sensor3 falling edge)
- `card_present` in 1: E-pass tag read OK
- `card_balance` in BAL_W: balance of tag currently read
- `valid_Epass` out 1: combinational; `card_present & (card_balance >= fee_now)`
- `num_veh` out 2: vehicles in zone
- `done` out 1: one-cycle pulse, cycle after `cal`
- `debit_ok` out 1: one-cycle pulse with `done` when the charge was taken
- `fee` out BAL_W: fee latched at `cal`
- `new_balance` out BAL_W: balance after debit, latched at `cal`
- `speeding` out 1: classification latched at `cal`

## Operation
- **Transit timer `t_cnt`:**
  - Priority is `reset` > `init` > `cal` > `count`.
  - `init` clears `t_cnt` to 0.
  - `count` increments `t_cnt`, saturating at all-ones with no wrap.
  - `cal` holds the value.
  - If `cal` and `count` are both asserted, the timer holds.
- **Fee, combinational:**
  - `fast = (t_cnt < FAST_LIMIT)`.
  - `fee_now = BASE_FEE + (fast ? FINE_FEE : 0)`, computed in BAL_W bits and saturating at all-ones.
  - A saturated `t_cnt` is always treated as slow.
- **Charge on `cal`:**
  - `fee <= fee_now` and `speeding <= fast`.
  - If `valid_Epass`: `new_balance <= card_balance - fee_now` and `debit_ok <= 1`.
  - Otherwise: `new_balance <= card_balance` and `debit_ok <= 0`.
  - `done <= 1` in both cases.
  - `done` and `debit_ok` clear on the following cycle.
  - A `cal` that is asserted while `done` is high is processed normally. Back-to-back `cal` pulses produce back-to-back `done` pulses.
- **Zone counter `num_veh`:**
  - `up` alone increments, saturating at 3.
  - `down` alone decrements, saturating at 0.
  - `up & down` together hold the count.
- **Reset:**
  - All registered outputs go to 0: `num_veh`, `done`, `debit_ok`, `fee`, `new_balance`, `speeding`, and also `t_cnt`.
  - Reset in the middle of a transit discards it; no `done` is emitted.

## Timing
- `valid_Epass` has zero latency from `t_cnt`, `card_present` and `card_balance`. It is valid in the same cycle as `cal`, which is the cycle the controller samples it.
- `done`, `debit_ok`, `fee`, `new_balance` and `speeding` have 1-cycle latency from `cal`. `fee`, `new_balance` and `speeding` hold until the next `cal` or `reset`.
- `num_veh` updates 1 cycle after `up`/`down`.
- `t_cnt` equals the number of cycles `count` was high since the last `init`.

## Configuration
- Macro: `TOLL_SPEED_FINE_EN`.
- **Defined:**
  - Fee is `BASE_FEE + FINE_FEE` when `fast`.
  - `speeding` output is live.
- **Undefined:**
  - Fee is always `BASE_FEE`.
  - `speeding` is tied to 0.
  - Comparator logic is removed; the timer still counts.

## Structure
- **Package `toll_pkg`:**
  - Default values of `TIME_W`, `BAL_W`, `FAST_LIMIT`, `BASE_FEE`, `FINE_FEE`.
  - `MAX_VEH = 3`.
  - The saturating-add helper function.
- **Sub-module `veh_zone_counter`:** 2-bit saturating up/down counter with hold on simultaneous up/down. It drives `num_veh`.

## Test plan
- **Slow paid pass:** `init`, `count` for 1500 cycles, `cal` with `card_present=1`, `card_balance=100` → `valid_Epass=1` during `cal`. Next cycle: `done=1`, `debit_ok=1`, `fee=20`, `new_balance=80`, `speeding=0`.
- **Speeding pass:** `count` for 400 cycles, `card_balance=100` → `fee=70`, `new_balance=30`, `speeding=1`. With `TOLL_SPEED_FINE_EN` undefined → `fee=20`, `speeding=0`.
- **Insufficient balance:** `count` for 400 cycles, `card_balance=60` → `valid_Epass=0`, `done=1`, `debit_ok=0`, `new_balance=60`.
- **Zone counter limits:**
  - 4× `up` → `num_veh` = 1, 2, 3, 3.
  - `up & down` at 3 → stays 3.
  - 4× `down` → 2, 1, 0, 0.
- **Timer saturation:** `TIME_W=4`, `FAST_LIMIT=20`, `count` for 30 cycles → `t_cnt=15` and the pass is classified slow: `fee=20`, `speeding=0`.
- **Reset mid-transit:** `count` for 100 cycles, then `reset` for 1 cycle → all outputs 0 and `t_cnt=0`. A later `cal` without `count` gives a speeding fee (`t_cnt=0 < FAST_LIMIT`).
